halton_scheduler: RTL and testbench
===================================

# halton_scheduler

Time-multiplexes one shared two-dimensional Halton point generator (pop/reseed interface, 32-bit index) among NUM_REQ independent requesters. Each requester owns a private sequence-index context, so each one sees its own uninterrupted Halton stream. For every granted request the block reseeds the generator with the requester's saved index, pops one point, and returns it on a response channel tagged with the requester ID. It sits between the consumer ports and the single generator instance.

## Interface
- NUM_REQ, 4: number of requesters (2..16)
- IDX_W, 32: context index / generator seed width
- DATA_W, 32: generator output width per dimension
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester point request
- req_ready  out  NUM_REQ  one-hot accept pulse, high only in the accept cycle
- cfg_we  in  1  context write strobe
- cfg_id  in  $clog2(NUM_REQ)  context to write
- cfg_index  in  IDX_W  new context index
- rsp_valid  out  1  response held until taken
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  $clog2(NUM_REQ)  requester ID of the response
- rsp_x0, rsp_x1  out  DATA_W  Halton point (dimension 0 and dimension 1)
- busy  out  1  high in every state except IDLE
- gen_reseed_enable, gen_pop_enable  out  1  generator controls
- gen_seed  out  IDX_W  generator seed
- gen_out_0, gen_out_1  in  DATA_W  generator outputs
- gen_valid  in  1  generator output valid

## Operation
- Contexts ctx[0..NUM_REQ-1] hold the last-consumed index of each requester. All reset to 0.
- The generator returns the point for seed+1. After each service, ctx[g] <= ctx[g]+1, modulo 2^IDX_W. 32'hFFFFFFFF wraps to 0.
- Round-robin arbitration:
  - Search starts at (last_grant+1) mod NUM_REQ.
  - last_grant resets to NUM_REQ-1, so requester 0 has first priority.
  - last_grant updates on accept.
- FSM states:
  - IDLE: if any req_valid, assert req_ready[g] combinationally, latch g, go to LOAD.
  - LOAD: gen_reseed_enable=1, gen_seed=ctx[g]. Next state POP.
  - POP: gen_pop_enable=1. Next state WAIT.
  - WAIT: when gen_valid=1, capture gen_out_0/1 into rsp_x0/x1, set rsp_id=g, increment ctx[g], go to RESP. Otherwise remain in WAIT.
  - RESP: rsp_valid=1. When rsp_ready=1, go to IDLE.
- Generator controls are low in every state except the one named above. gen_seed is 0 outside LOAD.
- cfg_we writes ctx[cfg_id] in any state.
  - If it coincides with the WAIT-capture increment of the same ID, the cfg write wins.
  - A write during LOAD to the ID being served does not affect the seed already driven in that cycle.
- Requests are not queued. A requester holds req_valid until it sees req_ready.
- rsp_x0, rsp_x1 and rsp_id are stable while rsp_valid=1 and rsp_ready=0.

## Timing
- Accept in cycle t (IDLE). LOAD at t+1, POP at t+2, WAIT at t+3 (with a one-cycle generator), rsp_valid from t+4.
- rsp_ready taken at t+4 returns the FSM to IDLE at t+5. Maximum throughput is one point per 5 cycles.
- WAIT absorbs extra generator latency with no timeout.
- Reset values:
  - All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_x0, rsp_x1, busy, gen_reseed_enable, gen_pop_enable, gen_seed.
  - State is IDLE, ctx all 0, last_grant = NUM_REQ-1.
- rst asserted in any state returns all of the above values on the following cycle. An in-flight request is dropped and its context is not incremented.

## Structure
- Package halton_sched_pkg:
  - state enum (IDLE, LOAD, POP, WAIT, RESP)
  - DEFAULT_IDX_W = 32 and DEFAULT_DATA_W = 32
- Sub-module rr_arbiter:
  - parameter N
  - inputs req[N], last_grant, en
  - outputs grant one-hot and grant_id; purely combinational priority rotate
- The context array and FSM live in halton_scheduler.

## Test plan
The bench pairs the block with the team's minimal Halton generator (index 1→1024/729, 2→512/1458, 3→1536/243).
- Reset, then only req_valid[0]:
  - req_ready[0] pulses at t, gen_seed=0 in LOAD
  - rsp at t+4: id 0, 1024/729
  - a second request returns 512/1458
- All four requesters hold req_valid, rsp_ready=1:
  - grants 0,1,2,3,0 at 5-cycle spacing
  - each requester's first response is 1024/729, its second 512/1458
- rsp_ready low for 10 cycles in RESP:
  - rsp_valid and data stable, no req_ready, busy=1
  - released on rsp_ready
- cfg_we id 2, index 2, then req_valid[2]:
  - gen_seed=2
  - response 1536/243, ctx[2]=3
- cfg ctx[1]=32'hFFFFFFFF, serve requester 1:
  - ctx[1] becomes 0
  - next service drives gen_seed=0 and returns 1024/729
- rst for one cycle during WAIT:
  - all outputs 0 next cycle, state IDLE
  - a following req_valid[0] returns 1024/729

Source files
------------

// File: rtl/halton_sched_pkg.sv
// ---------------------------------------------------------------------------
// halton_sched_pkg
//
// Shared definitions for the Halton point scheduler:
//   - state_t        : scheduler FSM states
//   - DEFAULT_IDX_W  : default width of a requester context / generator seed
//   - DEFAULT_DATA_W : default width of one generator output dimension
// ---------------------------------------------------------------------------
package halton_sched_pkg;

    localparam int DEFAULT_IDX_W  = 32;
    localparam int DEFAULT_DATA_W = 32;

    // IDLE : arbitrate and accept one request
    // LOAD : reseed the generator with the winner's saved index
    // POP  : ask the generator for one point
    // WAIT : hold until the generator reports a valid point
    // RESP : present the point until the consumer takes it
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        POP  = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin arbiter. The search for a winner starts at
// (last_grant + 1) mod N and wraps around, so the most recently served
// requester has the lowest priority.
//
// Ports:
//   req        in   N      request vector
//   last_grant in   ID_W   index of the previously granted requester
//   en         in   1      arbitration enable; grant is zero when low
//   grant      out  N      one-hot grant (all zero if no request or !en)
//   grant_id   out  ID_W   binary index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    always_comb begin
        logic            found;
        int              cand;
        logic [ID_W-1:0] cand_id;

        // NOTE: every variable written here gets a value before any branch;
        // a path that leaves one unassigned would infer a latch.
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        cand     = 0;
        cand_id  = '0;

        if (en) begin
            for (int k = 1; k <= N; k++) begin
                cand    = (int'(last_grant) + k) % N;
                cand_id = ID_W'(cand);
                if (!found && req[cand_id]) begin
                    found          = 1'b1;
                    grant[cand_id] = 1'b1;
                    grant_id       = cand_id;
                end
            end
        end
    end

endmodule

// File: rtl/halton_scheduler.sv
// ---------------------------------------------------------------------------
// halton_scheduler
//
// Shares one two-dimensional Halton generator among NUM_REQ requesters. Each
// requester owns a saved sequence index (its context). A granted request
// reseeds the generator with that index, pops one point (the point for
// seed+1), returns it tagged with the requester ID and advances the context.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_valid[NUM_REQ]  per-requester point request (held until req_ready)
//   req_ready[NUM_REQ]  one-hot accept pulse, combinational in IDLE
//   cfg_we/id/index     direct write of one context, accepted in any state
//   rsp_valid/ready     response handshake; rsp_* held until taken
//   rsp_id, rsp_x0/x1   requester ID and the two point coordinates
//   busy                high whenever the FSM is not IDLE
//   gen_reseed_enable   generator reseed strobe (LOAD only), seed on gen_seed
//   gen_pop_enable      generator pop strobe (POP only)
//   gen_out_0/1, gen_valid  generator point and its valid flag
// ---------------------------------------------------------------------------
module halton_scheduler
    import halton_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int IDX_W   = DEFAULT_IDX_W,
    parameter  int DATA_W  = DEFAULT_DATA_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,

    input  logic               cfg_we,
    input  logic [ID_W-1:0]    cfg_id,
    input  logic [IDX_W-1:0]   cfg_index,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [DATA_W-1:0]  rsp_x0,
    output logic [DATA_W-1:0]  rsp_x1,

    output logic               busy,

    output logic               gen_reseed_enable,
    output logic               gen_pop_enable,
    output logic [IDX_W-1:0]   gen_seed,
    input  logic [DATA_W-1:0]  gen_out_0,
    input  logic [DATA_W-1:0]  gen_out_1,
    input  logic               gen_valid
);

    state_t state, state_next;

    logic [ID_W-1:0]    grant_q;        // requester currently being served
    logic [ID_W-1:0]    last_grant_q;   // round-robin pointer
    logic [IDX_W-1:0]   ctx [NUM_REQ];  // last-consumed index per requester

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_grant_id;
    logic               arb_en;
    logic               accept;
    logic               capture;

    // Arbitration only happens in IDLE; gating with rst keeps req_ready low
    // in a reset cycle so no requester believes it was accepted.
    assign arb_en = (state == IDLE) && !rst;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .en         (arb_en),
        .grant      (arb_grant),
        .grant_id   (arb_grant_id)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: clocked blocks use non-blocking assignments only, so every
    // register samples values from before the edge regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next        = state;
        req_ready         = '0;
        accept            = 1'b0;
        capture           = 1'b0;
        gen_reseed_enable = 1'b0;
        gen_pop_enable    = 1'b0;
        gen_seed          = '0;
        rsp_valid         = 1'b0;
        busy              = (state != IDLE);

        case (state)
            IDLE: begin
                req_ready = arb_grant;
                if (|arb_grant) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // Seed comes straight from the stored context, so a cfg write
                // in this same cycle only lands after the seed is consumed.
                gen_reseed_enable = 1'b1;
                gen_seed          = ctx[grant_q];
                state_next        = POP;
            end
            POP: begin
                gen_pop_enable = 1'b1;
                state_next     = WAIT;
            end
            WAIT: begin
                // No timeout: a slow generator simply stretches this state.
                if (gen_valid) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Grant bookkeeping and response registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);   // requester 0 wins first
            rsp_id       <= '0;
            rsp_x0       <= '0;
            rsp_x1       <= '0;
        end else begin
            if (accept) begin
                grant_q      <= arb_grant_id;
                last_grant_q <= arb_grant_id;
            end
            // Only written on capture, so the response stays stable for as
            // long as RESP is stalled by the consumer.
            if (capture) begin
                rsp_id <= grant_q;
                rsp_x0 <= gen_out_0;
                rsp_x1 <= gen_out_1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Context array
    // -----------------------------------------------------------------------
    // NOTE: the contexts are a handful of flops, not a RAM macro, and every
    // stream must restart from index 0, so each entry is explicitly reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                ctx[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                // A configuration write overrides the post-service increment
                // when both target the same entry in the same cycle.
                if (cfg_we && (cfg_id == ID_W'(i))) begin
                    ctx[i] <= cfg_index;
                end else if (capture && (grant_q == ID_W'(i))) begin
                    ctx[i] <= ctx[i] + IDX_W'(1);   // wraps modulo 2^IDX_W
                end
            end
        end
    end

endmodule

// File: tb/tb_halton_scheduler.sv
// ---------------------------------------------------------------------------
// tb_halton_scheduler
//
// Drives halton_scheduler together with a behavioural two-dimensional Halton
// generator (base 2 scaled by 2^11, base 3 scaled by 3^7; index 1 -> 1024/729)
// and checks every response against a reference model that tracks each
// requester's index and the round-robin order with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_halton_scheduler;
    import halton_sched_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 32;
    localparam int DATA_W  = 32;
    localparam int ID_W    = $clog2(NUM_REQ);

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic               cfg_we;
    logic [ID_W-1:0]    cfg_id;
    logic [IDX_W-1:0]   cfg_index;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [DATA_W-1:0]  rsp_x0;
    logic [DATA_W-1:0]  rsp_x1;
    logic               busy;
    logic               gen_reseed_enable;
    logic               gen_pop_enable;
    logic [IDX_W-1:0]   gen_seed;
    logic [DATA_W-1:0]  gen_out_0;
    logic [DATA_W-1:0]  gen_out_1;
    logic               gen_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    halton_scheduler #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .cfg_we            (cfg_we),
        .cfg_id            (cfg_id),
        .cfg_index         (cfg_index),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_id            (rsp_id),
        .rsp_x0            (rsp_x0),
        .rsp_x1            (rsp_x1),
        .busy              (busy),
        .gen_reseed_enable (gen_reseed_enable),
        .gen_pop_enable    (gen_pop_enable),
        .gen_seed          (gen_seed),
        .gen_out_0         (gen_out_0),
        .gen_out_1         (gen_out_1),
        .gen_valid         (gen_valid)
    );

    // ---------------- Halton arithmetic ----------------
    function automatic logic [31:0] halton_x0(input logic [31:0] idx);
        longint unsigned v     = idx;
        longint unsigned acc   = 0;
        longint unsigned scale = 1024;
        for (int d = 0; d < 11; d++) begin
            acc   = acc + (v % 2) * scale;
            v     = v / 2;
            scale = scale / 2;
        end
        return acc[31:0];
    endfunction

    function automatic logic [31:0] halton_x1(input logic [31:0] idx);
        longint unsigned v     = idx;
        longint unsigned acc   = 0;
        longint unsigned scale = 729;
        for (int d = 0; d < 7; d++) begin
            acc   = acc + (v % 3) * scale;
            v     = v / 3;
            scale = scale / 3;
        end
        return acc[31:0];
    endfunction

    // ---------------- generator model (latency gen_lat >= 1) ----------------
    logic [IDX_W-1:0] gen_idx = '0;
    logic [IDX_W-1:0] gen_next;
    int               gen_rem = 0;
    int               gen_lat = 1;

    always @(posedge clk) begin
        if (rst) begin
            gen_rem <= 0;
        end else begin
            if (gen_reseed_enable) gen_idx <= gen_seed;
            if (gen_pop_enable) gen_rem <= gen_lat;
            else if (gen_rem > 0) gen_rem <= gen_rem - 1;
        end
    end

    assign gen_next  = gen_idx + 32'd1;
    assign gen_valid = (gen_rem == 1);
    assign gen_out_0 = gen_valid ? halton_x0(gen_next) : 32'hDEAD_BEEF;
    assign gen_out_1 = gen_valid ? halton_x1(gen_next) : 32'hBAAD_F00D;

    // ---------------- reference model ----------------
    logic [31:0] ctx_m [NUM_REQ];
    int          last_m;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] mask, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (mask[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REQ; i++) ctx_m[i] = '0;
        last_m = NUM_REQ - 1;
    endtask

    task automatic model_serve(input logic [NUM_REQ-1:0] mask, output int g,
                               output logic [31:0] seed, output logic [31:0] x0,
                               output logic [31:0] x1);
        g        = rr_pick(mask, last_m);
        last_m   = g;
        seed     = ctx_m[g];
        x0       = halton_x0(seed + 32'd1);
        x1       = halton_x1(seed + 32'd1);
        ctx_m[g] = seed + 32'd1;
    endtask

    // ---------------- stimulus helpers (observe only, no checking) ----------------
    typedef struct packed {
        int          gid;
        int          acc_cyc;
        int          rsp_lat;
        int          rid;
        logic [31:0] seed;
        logic [31:0] x0;
        logic [31:0] x1;
        bit          ok;
        bit          stable;
        bit          ctrl_ok;
    } txn_t;

    // All tasks start and end just after a rising edge.
    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        cfg_we = 1'b0; cfg_id = '0; cfg_index = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic do_cfg(input int id, input logic [31:0] idx);
        cfg_we = 1'b1; cfg_id = ID_W'(id); cfg_index = idx;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        ctx_m[id] = idx;
    endtask

    // Raise mask, wait for an accept, follow the transaction to its response,
    // stall the response for 'hold' cycles and release it. A cfg write can be
    // injected 'cfg_off' cycles after the accept cycle.
    task automatic serve(input logic [NUM_REQ-1:0] mask, input int hold, input int cfg_off,
                         input int cid, input logic [31:0] cidx, output txn_t t);
        logic [NUM_REQ-1:0] rdy;
        bit accepted;
        bit got_rsp;
        accepted = 1'b0; got_rsp = 1'b0; rdy = '0;
        t = '0; t.gid = -1; t.rid = -1; t.stable = 1'b1; t.ctrl_ok = 1'b1;
        rsp_ready = 1'b0;
        req_valid = mask;
        for (int k = 0; k < 20 && !accepted; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                accepted  = 1'b1;
                rdy       = req_ready;
                t.acc_cyc = cyc;
                if (!$onehot(req_ready) || (req_ready & ~mask) != '0) t.ctrl_ok = 1'b0;
                if (gen_reseed_enable || gen_pop_enable || gen_seed != '0 || busy) t.ctrl_ok = 1'b0;
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) t.gid = i;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            req_valid = '0;
            return;
        end
        req_valid = mask & ~rdy;
        for (int n = 1; n <= 40 && !got_rsp; n++) begin
            cfg_we = (n == cfg_off); cfg_id = ID_W'(cid); cfg_index = cidx;
            @(negedge clk);
            if (req_ready != '0 || busy !== 1'b1) t.ctrl_ok = 1'b0;
            if (gen_reseed_enable !== (n == 1) || gen_pop_enable !== (n == 2)) t.ctrl_ok = 1'b0;
            if (n == 1) t.seed = gen_seed;
            else if (gen_seed != '0) t.ctrl_ok = 1'b0;
            if (rsp_valid) begin
                got_rsp   = 1'b1;
                t.rsp_lat = n;
                t.x0      = rsp_x0;
                t.x1      = rsp_x1;
                t.rid     = int'(rsp_id);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        cfg_we = 1'b0;
        if (!got_rsp) begin
            req_valid = '0;
            return;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_x0 !== t.x0 || rsp_x1 !== t.x1 ||
                int'(rsp_id) != t.rid || req_ready != '0 || busy !== 1'b1) t.stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        req_valid = '0;
        t.ok = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if ({req_ready, rsp_valid, busy, gen_reseed_enable, gen_pop_enable} !== '0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0", {req_ready, rsp_valid, busy, gen_reseed_enable, gen_pop_enable}); end
        total++; if ({rsp_id, rsp_x0, rsp_x1} !== '0) begin
            bad++; $display("FAIL reset_rsp: got id=%0d x0=%0d x1=%0d want 0", rsp_id, rsp_x0, rsp_x1); end
        total++; if (gen_seed !== '0) begin
            bad++; $display("FAIL reset_seed: got %h want 0", gen_seed); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        txn_t t;
        int eg; logic [31:0] es, ex0, ex1;
        gen_lat = 1;
        serve(4'b0001, 0, -1, 0, '0, t);
        model_serve(4'b0001, eg, es, ex0, ex1);
        total++; if (t.ok !== 1'b1 || t.ctrl_ok !== 1'b1) begin
            bad++; $display("FAIL single_handshake: got ok=%0d ctrl=%0d want 1/1", t.ok, t.ctrl_ok); end
        total++; if (t.gid != 0 || t.rid != 0 || t.seed !== 32'd0) begin
            bad++; $display("FAIL single_grant: got gid=%0d rid=%0d seed=%0d want 0/0/0", t.gid, t.rid, t.seed); end
        total++; if (t.x0 !== 32'd1024 || t.x1 !== 32'd729 || t.rsp_lat != 4) begin
            bad++; $display("FAIL single_point1: got %0d/%0d lat=%0d want 1024/729 lat=4", t.x0, t.x1, t.rsp_lat); end
        serve(4'b0001, 0, -1, 0, '0, t);
        model_serve(4'b0001, eg, es, ex0, ex1);
        total++; if (t.ok !== 1'b1 || t.seed !== 32'd1 || t.x0 !== 32'd512 || t.x1 !== 32'd1458) begin
            bad++; $display("FAIL single_point2: got ok=%0d seed=%0d %0d/%0d want seed=1 512/1458", t.ok, t.seed, t.x0, t.x1); end
    endtask

    task automatic test_round_robin();
        txn_t t;
        int eg, prev_cyc; logic [31:0] es, ex0, ex1;
        do_reset();
        gen_lat = 1;
        prev_cyc = 0;
        for (int i = 0; i < 5; i++) begin
            serve(4'b1111, 0, -1, 0, '0, t);
            model_serve(4'b1111, eg, es, ex0, ex1);
            total++; if (t.gid != eg || t.rid != eg || t.gid != (i % 4)) begin
                bad++; $display("FAIL rr_grant%0d: got gid=%0d rid=%0d want %0d", i, t.gid, t.rid, eg); end
            total++; if (t.x0 !== ex0 || t.x1 !== ex1 || t.seed !== es) begin
                bad++; $display("FAIL rr_point%0d: got %0d/%0d seed=%0d want %0d/%0d seed=%0d", i, t.x0, t.x1, t.seed, ex0, ex1, es); end
            if (i > 0) begin
                total++; if (t.acc_cyc - prev_cyc != 5) begin
                    bad++; $display("FAIL rr_spacing%0d: got %0d want 5", i, t.acc_cyc - prev_cyc); end
            end
            prev_cyc = t.acc_cyc;
        end
    endtask

    task automatic test_backpressure();
        txn_t t;
        int eg; logic [31:0] es, ex0, ex1;
        logic [NUM_REQ-1:0] mask;
        gen_lat = 1;
        mask = NUM_REQ'(1) << $urandom_range(0, NUM_REQ - 1);
        serve(mask, 10, -1, 0, '0, t);
        model_serve(mask, eg, es, ex0, ex1);
        total++; if (t.ok !== 1'b1 || t.stable !== 1'b1 || t.ctrl_ok !== 1'b1) begin
            bad++; $display("FAIL bp_stall: got ok=%0d stable=%0d ctrl=%0d want 1/1/1", t.ok, t.stable, t.ctrl_ok); end
        total++; if (t.gid != eg || t.x0 !== ex0 || t.x1 !== ex1) begin
            bad++; $display("FAIL bp_point: got gid=%0d %0d/%0d want %0d %0d/%0d", t.gid, t.x0, t.x1, eg, ex0, ex1); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release: got busy=%0d rsp_valid=%0d want 0/0", busy, rsp_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_cfg_write();
        txn_t t;
        int eg; logic [31:0] es, ex0, ex1;
        gen_lat = 1;
        do_cfg(2, 32'd2);
        serve(4'b0100, 0, -1, 0, '0, t);
        model_serve(4'b0100, eg, es, ex0, ex1);
        total++; if (t.seed !== 32'd2 || t.x0 !== 32'd1536 || t.x1 !== 32'd243 || t.rid != 2) begin
            bad++; $display("FAIL cfg_point: got seed=%0d %0d/%0d rid=%0d want 2 1536/243 2", t.seed, t.x0, t.x1, t.rid); end
        serve(4'b0100, 0, -1, 0, '0, t);
        model_serve(4'b0100, eg, es, ex0, ex1);
        total++; if (t.seed !== 32'd3 || t.x0 !== ex0 || t.x1 !== ex1) begin
            bad++; $display("FAIL cfg_incr: got seed=%0d %0d/%0d want 3 %0d/%0d", t.seed, t.x0, t.x1, ex0, ex1); end
        // write to the served context while LOAD drives its seed
        serve(4'b1000, 0, 1, 3, 32'd100, t);
        model_serve(4'b1000, eg, es, ex0, ex1);
        total++; if (t.seed !== es || t.x0 !== ex0 || t.x1 !== ex1) begin
            bad++; $display("FAIL cfg_load: got seed=%0d %0d/%0d want %0d %0d/%0d", t.seed, t.x0, t.x1, es, ex0, ex1); end
        do_cfg(3, 32'd0);
        // write colliding with the capture increment: the write wins
        serve(4'b1000, 0, 3, 3, 32'd7, t);
        model_serve(4'b1000, eg, es, ex0, ex1);
        ctx_m[3] = 32'd7;
        total++; if (t.seed !== 32'd0 || t.x0 !== 32'd1024 || t.x1 !== 32'd729) begin
            bad++; $display("FAIL cfg_wait_pt: got seed=%0d %0d/%0d want 0 1024/729", t.seed, t.x0, t.x1); end
        serve(4'b1000, 0, -1, 0, '0, t);
        model_serve(4'b1000, eg, es, ex0, ex1);
        total++; if (t.seed !== 32'd7 || t.x0 !== ex0 || t.x1 !== ex1) begin
            bad++; $display("FAIL cfg_wait_win: got seed=%0d %0d/%0d want 7 %0d/%0d", t.seed, t.x0, t.x1, ex0, ex1); end
    endtask

    task automatic test_wrap();
        txn_t t;
        int eg; logic [31:0] es, ex0, ex1;
        gen_lat = 1;
        do_cfg(1, 32'hFFFF_FFFF);
        serve(4'b0010, 0, -1, 0, '0, t);
        model_serve(4'b0010, eg, es, ex0, ex1);
        total++; if (t.seed !== 32'hFFFF_FFFF || t.x0 !== ex0 || t.x1 !== ex1) begin
            bad++; $display("FAIL wrap_max: got seed=%h %0d/%0d want ffffffff %0d/%0d", t.seed, t.x0, t.x1, ex0, ex1); end
        serve(4'b0010, 0, -1, 0, '0, t);
        model_serve(4'b0010, eg, es, ex0, ex1);
        total++; if (t.seed !== 32'd0 || t.x0 !== 32'd1024 || t.x1 !== 32'd729) begin
            bad++; $display("FAIL wrap_zero: got seed=%h %0d/%0d want 0 1024/729", t.seed, t.x0, t.x1); end
    endtask

    task automatic test_reset_in_wait();
        txn_t t;
        int eg; logic [31:0] es, ex0, ex1;
        bit accepted;
        accepted = 1'b0;
        gen_lat = 6;
        req_valid = 4'b0001;
        for (int k = 0; k < 20 && !accepted; k++) begin
            @(negedge clk);
            accepted = (req_ready != '0);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        total++; if (!accepted) begin
            bad++; $display("FAIL rstwait_accept: got no req_ready want accept"); end
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rstwait_inwait: got busy=%0d rsp_valid=%0d want 1/0", busy, rsp_valid); end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        total++; if ({req_ready, rsp_valid, busy, gen_reseed_enable, gen_pop_enable, gen_seed, rsp_id, rsp_x0, rsp_x1} !== '0) begin
            bad++; $display("FAIL rstwait_zero: got busy=%0d rsp_valid=%0d seed=%h x0=%0d want all 0", busy, rsp_valid, gen_seed, rsp_x0); end
        @(posedge clk);
        #1 gen_lat = 1;
        serve(4'b0001, 0, -1, 0, '0, t);
        model_serve(4'b0001, eg, es, ex0, ex1);
        total++; if (t.ok !== 1'b1 || t.gid != 0 || t.seed !== 32'd0 || t.x0 !== 32'd1024 || t.x1 !== 32'd729) begin
            bad++; $display("FAIL rstwait_after: got ok=%0d gid=%0d seed=%0d %0d/%0d want 1 0 0 1024/729", t.ok, t.gid, t.seed, t.x0, t.x1); end
    endtask

    task automatic test_random();
        txn_t t;
        int eg, hold; logic [31:0] es, ex0, ex1;
        logic [NUM_REQ-1:0] mask;
        for (int i = 0; i < 40; i++) begin
            mask    = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            hold    = $urandom_range(0, 3);
            gen_lat = $urandom_range(1, 4);
            if ($urandom_range(0, 3) == 0)
                do_cfg($urandom_range(0, NUM_REQ - 1),
                       ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 50)));
            serve(mask, hold, -1, 0, '0, t);
            model_serve(mask, eg, es, ex0, ex1);
            total++; if (t.ok !== 1'b1 || t.ctrl_ok !== 1'b1 || t.stable !== 1'b1 || t.rsp_lat != 3 + gen_lat) begin
                bad++; $display("FAIL rand%0d_flow: got ok=%0d ctrl=%0d stable=%0d lat=%0d want 1/1/1 lat=%0d",
                                i, t.ok, t.ctrl_ok, t.stable, t.rsp_lat, 3 + gen_lat); end
            total++; if (t.gid != eg || t.rid != eg) begin
                bad++; $display("FAIL rand%0d_grant: got gid=%0d rid=%0d want %0d (mask %b)", i, t.gid, t.rid, eg, mask); end
            total++; if (t.seed !== es || t.x0 !== ex0 || t.x1 !== ex1) begin
                bad++; $display("FAIL rand%0d_point: got seed=%h %0d/%0d want %h %0d/%0d", i, t.seed, t.x0, t.x1, es, ex0, ex1); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_cfg_write();
        test_wrap();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
